// File: rtl/counter_sequencer.sv
// Command sequencer for the dual counter block: round-robin arbitration between
// requesters A and B, then drives the counter's Reset/En/Slt for one command.
module counter_sequencer #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ValidA,
  input  logic [1:0]       OpA,
  input  logic [LEN_W-1:0] LenA,
  output logic             ReadyA,
  input  logic             ValidB,
  input  logic [1:0]       OpB,
  input  logic [LEN_W-1:0] LenB,
  output logic             ReadyB,
  input  logic             Hold,
  output logic             CntRst,
  output logic             CntEn,
  output logic             CntSlt,
  output logic             Busy,
  output logic             Done,
  output logic             DoneId
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_RUN0  = 2'b01;
  localparam logic [1:0] OP_RUN1  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             ptr, ptr_nxt;            // 0 = A has priority, 1 = B
  logic [LEN_W-1:0] remaining, remaining_nxt;
  logic [LEN_W-1:0] acc_len;
  logic [1:0]       op, op_nxt;
  logic             owner, owner_nxt;
  logic             accept;
  logic             cnt_rst_nxt, cnt_en_nxt, cnt_slt_nxt;
  logic             busy_nxt, done_nxt, done_id_nxt;

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      ptr       <= 1'b0;
      remaining <= '0;
      op        <= OP_NOP;
      owner     <= 1'b0;
      CntRst    <= 1'b0;
      CntEn     <= 1'b0;
      CntSlt    <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DoneId    <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      remaining <= remaining_nxt;
      op        <= op_nxt;
      owner     <= owner_nxt;
      CntRst    <= cnt_rst_nxt;
      CntEn     <= cnt_en_nxt;
      CntSlt    <= cnt_slt_nxt;
      Busy      <= busy_nxt;
      Done      <= done_nxt;
      DoneId    <= done_id_nxt;
    end
  end

  // Arbitration, next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    op_nxt        = op;
    owner_nxt     = owner;
    cnt_rst_nxt   = 1'b0;
    cnt_en_nxt    = 1'b0;
    cnt_slt_nxt   = CntSlt;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    done_id_nxt   = 1'b0;

    ReadyA  = (state == ST_IDLE) && !Reset && ValidA && (!ptr || !ValidB);
    ReadyB  = (state == ST_IDLE) && !Reset && ValidB && (ptr || !ValidA);
    accept  = ReadyA || ReadyB;
    acc_len = ReadyB ? LenB : LenA;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          owner_nxt = ReadyB;
          op_nxt    = ReadyB ? OpB : OpA;
          ptr_nxt   = ReadyA;
          // Commands with no counter work skip EXEC so Done lands at T+1
          case (op_nxt)
            OP_CLEAR: begin
              cnt_rst_nxt = 1'b1;
              state_nxt   = ST_EXEC;
            end
            OP_RUN0, OP_RUN1: begin
              if (acc_len != '0) begin
                cnt_en_nxt    = 1'b1;
                cnt_slt_nxt   = op_nxt[1];
                remaining_nxt = acc_len - LEN_W'(1);
                state_nxt     = ST_EXEC;
              end else begin
                state_nxt = ST_DONE;
              end
            end
            default: state_nxt = ST_DONE;
          endcase
        end
      end
      ST_EXEC: begin
        // remaining counts enable cycles still to issue after the current one
        if ((op == OP_CLEAR) || (remaining == '0)) begin
          state_nxt = ST_DONE;
        end else if (!Hold) begin
          cnt_en_nxt    = 1'b1;
          remaining_nxt = remaining - LEN_W'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    done_nxt    = (state_nxt == ST_DONE);
    done_id_nxt = done_nxt && owner_nxt;
    busy_nxt    = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural model of the attached
// dual counter (counter 0 per enabled cycle, counter 1 per four enabled cycles).
module tb_counter_sequencer;

  localparam int unsigned LEN_W = 8;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             ValidA = 1'b0;
  logic [1:0]       OpA = 2'b00;
  logic [LEN_W-1:0] LenA = '0;
  logic             ReadyA;
  logic             ValidB = 1'b0;
  logic [1:0]       OpB = 2'b00;
  logic [LEN_W-1:0] LenB = '0;
  logic             ReadyB;
  logic             Hold = 1'b0;
  logic             CntRst, CntEn, CntSlt, Busy, Done, DoneId;

  int checks = 0;
  int failures = 0;
  int o0 = 0, o1 = 0, pre = 0;
  int remA, remB, ng, nd, both, seen;
  int grants[4];
  int dids[4];
  int exp_g[4] = '{0, 1, 0, 1};

  always #5 Clk = ~Clk;

  counter_sequencer #(.LEN_W(LEN_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .ValidA(ValidA), .OpA(OpA), .LenA(LenA), .ReadyA(ReadyA),
    .ValidB(ValidB), .OpB(OpB), .LenB(LenB), .ReadyB(ReadyB),
    .Hold(Hold), .CntRst(CntRst), .CntEn(CntEn), .CntSlt(CntSlt),
    .Busy(Busy), .Done(Done), .DoneId(DoneId)
  );

  // Attached counter model
  always @(posedge Clk) begin
    if (Reset || CntRst) begin
      o0 <= 0; o1 <= 0; pre <= 0;
    end else if (CntEn) begin
      if (!CntSlt) o0 <= o0 + 1;
      else if (pre == 3) begin pre <= 0; o1 <= o1 + 1; end
      else pre <= pre + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; ValidA = 1'b0; ValidB = 1'b0; Hold = 1'b0;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  // Issue one command, follow it to Done and compare against hand-derived values
  task automatic run_cmd(input string tag, input logic who, input logic [1:0] op,
                         input logic [LEN_W-1:0] len, input int hs, input int hl,
                         input int exp_done, input int exp_en, input int exp_rst,
                         input int exp_o0, input int exp_o1);
    int en, rst, bad, dk;
    logic id;
    en = 0; rst = 0; bad = 0; dk = -1; id = 1'b0;
    @(posedge Clk); #1;
    if (!who) begin ValidA = 1'b1; OpA = op; LenA = len; end
    else      begin ValidB = 1'b1; OpB = op; LenB = len; end
    #1;
    check({tag, "_ready"}, who ? ReadyB : ReadyA, 1);
    check({tag, "_other_ready"}, who ? ReadyA : ReadyB, 0);
    @(posedge Clk); #1;
    ValidA = 1'b0; ValidB = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      if (CntEn) en++;
      if (CntRst) rst++;
      if (CntEn && (CntSlt !== op[1])) bad++;
      if (CntEn && CntRst) bad++;
      if (Busy !== 1'b1) bad++;
      if (Done) begin dk = k; id = DoneId; break; end
      Hold = (k >= hs) && (k < hs + hl);
      @(posedge Clk); #1;
    end
    Hold = 1'b0;
    check({tag, "_done_cycle"}, dk, exp_done);
    check({tag, "_en_cycles"}, en, exp_en);
    check({tag, "_rst_cycles"}, rst, exp_rst);
    check({tag, "_done_id"}, id, who);
    check({tag, "_bad_cycles"}, bad, 0);
    check({tag, "_out0"}, o0, exp_o0);
    check({tag, "_out1"}, o1, exp_o1);
    @(posedge Clk); #1;
    check({tag, "_idle_after"}, {Busy, Done, CntEn, CntRst}, 0);
  endtask

  initial begin
    // Reset held with a pending request
    ValidA = 1'b1; OpA = 2'b01; LenA = 8'd3;
    repeat (3) begin
      @(posedge Clk); #1;
      check("rst_readyA", ReadyA, 0);
    end
    check("rst_outputs", {CntRst, CntEn, CntSlt, Busy, Done, DoneId}, 0);
    check("rst_counters", o0 + o1, 0);
    Reset = 1'b0; ValidA = 1'b0;

    run_cmd("a_run0_5", 1'b0, 2'b01, 8'd5, 0, 0, 6, 5, 0, 5, 0);
    run_cmd("b_run1_8", 1'b1, 2'b10, 8'd8, 0, 0, 9, 8, 0, 5, 2);

    // Both requesters contending for four RUN0 Len=2 commands
    do_reset();
    OpA = 2'b01; LenA = 8'd2; OpB = 2'b01; LenB = 8'd2;
    ValidA = 1'b1; ValidB = 1'b1;
    remA = 2; remB = 2; ng = 0; nd = 0; both = 0;
    #1;
    for (int c = 0; c < 100 && nd < 4; c++) begin
      if (ReadyA && ReadyB) both++;
      if (ReadyA && ng < 4) begin grants[ng] = 0; ng++; remA--; end
      else if (ReadyB && ng < 4) begin grants[ng] = 1; ng++; remB--; end
      if (Done && nd < 4) begin dids[nd] = int'(DoneId); nd++; end
      @(posedge Clk); #1;
      if (remA == 0) ValidA = 1'b0;
      if (remB == 0) ValidB = 1'b0;
      #1;
    end
    ValidA = 1'b0; ValidB = 1'b0;
    check("arb_grants", ng, 4);
    check("arb_dones", nd, 4);
    check("arb_both_ready", both, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("arb_grant%0d", i), grants[i], exp_g[i]);
      check($sformatf("arb_doneid%0d", i), dids[i], exp_g[i]);
    end
    check("arb_out0", o0, 8);

    run_cmd("a_hold", 1'b0, 2'b01, 8'd4, 1, 3, 8, 4, 0, 12, 0);

    do_reset();
    run_cmd("a_run0_7", 1'b0, 2'b01, 8'd7, 0, 0, 8, 7, 0, 7, 0);
    run_cmd("b_run1_4", 1'b1, 2'b10, 8'd4, 0, 0, 5, 4, 0, 7, 1);
    run_cmd("a_clear", 1'b0, 2'b11, 8'd0, 1, 1, 2, 0, 1, 0, 0);
    run_cmd("b_run1_len0", 1'b1, 2'b10, 8'd0, 0, 0, 1, 0, 0, 0, 0);
    run_cmd("a_nop", 1'b0, 2'b00, 8'd9, 0, 0, 1, 0, 0, 0, 0);
    run_cmd("b_run0_max", 1'b1, 2'b01, 8'd255, 0, 0, 256, 255, 0, 255, 0);

    // Reset in the middle of a run: no Done, back to IDLE with ptr on A
    @(posedge Clk); #1;
    ValidA = 1'b1; OpA = 2'b01; LenA = 8'd10;
    @(posedge Clk); #1;
    ValidA = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    check("midrst_running", CntEn, 1);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    seen = 0;
    repeat (6) begin
      if (Done || Busy || CntEn) seen++;
      @(posedge Clk); #1;
    end
    check("midrst_no_done", seen, 0);
    check("midrst_out0", o0, 0);
    ValidA = 1'b1; ValidB = 1'b1;
    #1;
    check("midrst_ptr_readyA", ReadyA, 1);
    check("midrst_ptr_readyB", ReadyB, 0);
    ValidA = 1'b0; ValidB = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
